// File: rtl/song_sequencer.sv
// song_sequencer
//   Steps the 6-bit note index that drives the harmonic tone generators
//   through a song at a programmable tempo. The game logic issues
//   start/stop/pause/loop commands. This block owns all step timing and
//   drives the shared note bus plus status pulses.
//
// State table:
//   state  | meaning
//   IDLE   | not playing, note bus held at REST_IDX
//   PLAY   | sounding note idx, tick counting toward step_len-1
//   PAUSED | tick/idx frozen, note muted to REST_IDX, playing still high
//
// Ports:
//   CLOCK_50   in   system clock (50 MHz)
//   reset      in   synchronous, active-high reset
//   start      in   begin (or restart) playback from step 0
//   stop       in   abort to IDLE; wins over start
//   pause      in   hold playback while high
//   loop_en    in   wrap to step 0 after the last step, sampled at the boundary
//   tempo_sel  in   step length = TICKS_PER_STEP >> tempo_sel, latched per step
//   note       out  note index to the tone generators
//   step_pulse out  one-cycle pulse at the start of every step
//   playing    out  high in PLAY and PAUSED
//   done       out  one-cycle pulse when a non-looping song completes
//
// All outputs are registered.

module song_sequencer #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int SONG_LEN       = 47,
    parameter int REST_IDX       = 63
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop_en,
    input  logic [1:0] tempo_sel,
    output logic [5:0] note,
    output logic       step_pulse,
    output logic       playing,
    output logic       done
);

    localparam logic [23:0] TPS      = 24'(TICKS_PER_STEP);
    localparam logic [5:0]  LAST_IDX = 6'(SONG_LEN - 1);
    localparam logic [5:0]  REST     = 6'(REST_IDX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [23:0] tick, tick_nxt;
    logic [23:0] step_len, step_len_nxt;
    logic [5:0]  note_nxt;
    logic        step_pulse_nxt, playing_nxt, done_nxt;
    logic [23:0] tempo_len;

    assign tempo_len = TPS >> tempo_sel;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            tick       <= '0;
            step_len   <= TPS;
            note       <= REST;
            step_pulse <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tick       <= tick_nxt;
            step_len   <= step_len_nxt;
            note       <= note_nxt;
            step_pulse <= step_pulse_nxt;
            playing    <= playing_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        tick_nxt       = tick;
        step_len_nxt   = step_len;
        note_nxt       = note;
        step_pulse_nxt = 1'b0;
        playing_nxt    = playing;
        done_nxt       = 1'b0;

        if (stop) begin
            state_nxt   = IDLE;
            idx_nxt     = '0;
            tick_nxt    = '0;
            note_nxt    = REST;
            playing_nxt = 1'b0;
        end else if (start) begin
            state_nxt      = PLAY;
            idx_nxt        = '0;
            tick_nxt       = '0;
            step_len_nxt   = tempo_len;
            note_nxt       = '0;
            step_pulse_nxt = 1'b1;
            playing_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    note_nxt    = REST;
                    playing_nxt = 1'b0;
                end
                PLAY: begin
                    // Pause is checked before the boundary so a step boundary
                    // coinciding with pause is deferred until after resume.
                    if (pause) begin
                        state_nxt = PAUSED;
                        note_nxt  = REST;
                    end else if (tick == step_len - 24'd1) begin
                        tick_nxt     = '0;
                        step_len_nxt = tempo_len;
                        if (idx == LAST_IDX) begin
                            if (loop_en) begin
                                idx_nxt        = '0;
                                note_nxt       = '0;
                                step_pulse_nxt = 1'b1;
                            end else begin
                                state_nxt   = IDLE;
                                idx_nxt     = '0;
                                note_nxt    = REST;
                                playing_nxt = 1'b0;
                                done_nxt    = 1'b1;
                            end
                        end else begin
                            idx_nxt        = idx + 6'd1;
                            note_nxt       = idx + 6'd1;
                            step_pulse_nxt = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick + 24'd1;
                    end
                end
                PAUSED: begin
                    // Resume edge only restores the note; tick continues from
                    // its frozen value on the following cycles.
                    if (!pause) begin
                        state_nxt = PLAY;
                        note_nxt  = idx;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    idx_nxt     = '0;
                    tick_nxt    = '0;
                    note_nxt    = REST;
                    playing_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic [5:0] note;
    logic       step_pulse;
    logic       playing;
    logic       done;

    int checks   = 0;
    int failures = 0;

    song_sequencer #(
        .TICKS_PER_STEP(8),
        .SONG_LEN      (4),
        .REST_IDX      (63)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .note      (note),
        .step_pulse(step_pulse),
        .playing   (playing),
        .done      (done)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int n, input int sp,
                           input int pl, input int dn);
        chk({tag, ".note"},       int'(note),       n);
        chk({tag, ".step_pulse"}, int'(step_pulse), sp);
        chk({tag, ".playing"},    int'(playing),    pl);
        chk({tag, ".done"},       int'(done),       dn);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        loop_en = 1'b0; tempo_sel = 2'd0;
        step();
        step();
        chk_out("reset", 63, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_out("idle", 63, 0, 0, 0);

        // Basic non-looping song: 4 steps of 8 cycles, done 32 cycles later.
        pulse_start();
        chk_out("play.c0", 0, 1, 1, 0);
        for (int c = 1; c < 32; c++) begin
            step();
            chk_out("play.run", c / 8, (c % 8 == 0) ? 1 : 0, 1, 0);
        end
        step();
        chk_out("play.done", 63, 0, 0, 1);
        step();
        chk_out("play.after", 63, 0, 0, 0);

        // Looping song wraps to step 0 with a pulse and no done.
        loop_en = 1'b1;
        pulse_start();
        chk_out("loop.c0", 0, 1, 1, 0);
        for (int c = 1; c < 40; c++) begin
            step();
            chk_out("loop.run", (c / 8) % 4, (c % 8 == 0) ? 1 : 0, 1, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_out("loop.stop", 63, 0, 0, 0);
        loop_en = 1'b0;

        // Tempo change during step 1 applies from step 2 onward.
        pulse_start();
        for (int c = 1; c <= 8; c++) step();
        chk_out("tempo.s1", 1, 1, 1, 0);
        tempo_sel = 2'd2;
        for (int c = 9; c <= 15; c++) begin
            step();
            chk_out("tempo.s1hold", 1, 0, 1, 0);
        end
        step();
        chk_out("tempo.s2", 2, 1, 1, 0);
        step();
        chk_out("tempo.s2b", 2, 0, 1, 0);
        step();
        chk_out("tempo.s3", 3, 1, 1, 0);
        step();
        chk_out("tempo.s3b", 3, 0, 1, 0);
        step();
        chk_out("tempo.done", 63, 0, 0, 1);
        tempo_sel = 2'd0;

        // Pause for 5 cycles at tick 3 of step 1.
        pulse_start();
        for (int c = 1; c <= 11; c++) step();
        chk_out("pause.pre", 1, 0, 1, 0);
        pause = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out("pause.held", 63, 0, 1, 0);
        end
        pause = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out("pause.resume", 1, 0, 1, 0);
        end
        step();
        chk_out("pause.next", 2, 1, 1, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_out("pause.stop", 63, 0, 0, 0);

        // stop and start together -> IDLE, idx cleared, no done.
        pulse_start();
        for (int c = 1; c <= 10; c++) step();
        chk_out("ss.pre", 1, 0, 1, 0);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk_out("ss.idle", 63, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk_out("ss.quiet", 63, 0, 0, 0);
        end
        pulse_start();
        chk_out("ss.restart", 0, 1, 1, 0);
        for (int c = 1; c <= 8; c++) step();
        chk_out("ss.step1", 1, 1, 1, 0);

        // Restart while playing begins again at step 0.
        pulse_start();
        chk_out("restart", 0, 1, 1, 0);

        // Synchronous reset during step 2 of a looping song.
        loop_en = 1'b1;
        for (int c = 1; c <= 17; c++) step();
        chk_out("rst.pre", 2, 0, 1, 0);
        reset = 1'b1;
        step();
        chk_out("rst.now", 63, 0, 0, 0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk_out("rst.idle", 63, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
